// File: rtl/router_pkg.sv
// Shared router definitions: scheduler state encoding, tail-flag index and width helpers.
package router_pkg;

  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StLocked = 1'b1
  } sched_state_e;

  // Index of the tail flag within a flit (last flit of packet when set).
  function automatic int unsigned tail_bit(input int unsigned flit_width);
    return flit_width - 1;
  endfunction

  // Bits needed to count 0..n-1; never below one bit.
  function automatic int unsigned clog2_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester after ptr, with wrap-around.
module rr_arbiter
  import router_pkg::*;
#(
  parameter int unsigned num_req = 4,
  localparam int unsigned idx_w = clog2_w(num_req)
) (
  input  logic [num_req-1:0] req,
  input  logic [idx_w-1:0]   ptr,
  output logic [num_req-1:0] gnt,
  output logic [idx_w-1:0]   gnt_idx,
  output logic               gnt_valid
);

  // Scan ptr+1 .. ptr+num_req so the last winner has the lowest priority.
  always_comb begin
    logic [idx_w-1:0] cand;
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int unsigned off = 1; off <= num_req; off++) begin
      cand = idx_w'((32'(ptr) + off) % num_req);
      if (!gnt_valid && req[cand]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand;
        gnt[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_port_scheduler.sv
// Output-port scheduler: per-packet round-robin with grant held until the tail flit,
// gated by downstream credits. Optional lock watchdog under `LOCK_WATCHDOG_EN.
module rr_port_scheduler
  import router_pkg::*;
#(
  parameter int unsigned num_req         = 4,
  parameter int unsigned flit_width      = 64,
  parameter int unsigned credit_max      = 8,
  parameter int unsigned watchdog_cycles = 256,
  localparam int unsigned idx_w  = clog2_w(num_req),
  localparam int unsigned cred_w = clog2_w(credit_max + 1)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [num_req-1:0]            req_empty,
  input  logic [num_req*flit_width-1:0] req_flit,
  output logic [num_req-1:0]            consume,
  input  logic                          credit_return,
  output logic [flit_width-1:0]         out_flit,
  output logic                          out_valid,
  output logic [idx_w-1:0]              grant_id,
  output logic                          locked,
  output logic [cred_w-1:0]             credits,
  output logic                          lock_err
);

  localparam int unsigned tail_idx = tail_bit(flit_width);

  sched_state_e          state_q, state_d;
  logic [idx_w-1:0]      ptr_q, ptr_d, grant_q, grant_d;
  logic [cred_w-1:0]     credits_q, credits_d;
  logic [flit_width-1:0] out_flit_q, sel_flit;
  logic                  out_valid_q;
  logic [num_req-1:0]    req_vec, arb_gnt;
  logic [idx_w-1:0]      arb_idx, sel_idx;
  logic                  arb_valid, sel_valid, send, wd_hit;

  assign req_vec = ~req_empty;

  rr_arbiter #(
    .num_req(num_req)
  ) u_arb (
    .req      (req_vec),
    .ptr      (ptr_q),
    .gnt      (arb_gnt),
    .gnt_idx  (arb_idx),
    .gnt_valid(arb_valid)
  );

  // Pick the candidate: arbiter winner when idle, the locked owner otherwise.
  always_comb begin
    sel_idx   = (state_q == StIdle) ? arb_idx : grant_q;
    sel_valid = (state_q == StIdle) ? arb_valid : !req_empty[grant_q];
    send      = !rst && (credits_q != '0) && sel_valid;
    sel_flit  = req_flit[sel_idx*flit_width +: flit_width];
    consume   = send ? (num_req'(1) << sel_idx) : '0;
  end

`ifdef LOCK_WATCHDOG_EN
  localparam int unsigned wd_w = clog2_w(watchdog_cycles);
  logic [wd_w-1:0] wd_q, wd_d;
  logic            lock_err_q;

  // Count locked cycles with an empty owner; credit stalls neither count nor clear.
  always_comb begin
    wd_d   = wd_q;
    wd_hit = 1'b0;
    if (state_q != StLocked || send) begin
      wd_d = '0;
    end else if (req_empty[grant_q]) begin
      if (wd_q == wd_w'(watchdog_cycles - 1)) begin
        wd_hit = 1'b1;
        wd_d   = '0;
      end else begin
        wd_d = wd_q + wd_w'(1);
      end
    end
  end

  // Watchdog counter and one-cycle release flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_q       <= '0;
      lock_err_q <= 1'b0;
    end else begin
      wd_q       <= wd_d;
      lock_err_q <= wd_hit;
    end
  end

  assign lock_err = lock_err_q;
`else
  assign wd_hit   = 1'b0;
  assign lock_err = 1'b0;
`endif

  // Next-state: grant on the first flit, release on tail (or watchdog expiry).
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (send) begin
          ptr_d   = sel_idx;
          grant_d = sel_idx;
          if (!sel_flit[tail_idx]) state_d = StLocked;
        end
      end
      StLocked: begin
        if ((send && sel_flit[tail_idx]) || wd_hit) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Credit bookkeeping; a simultaneous send and return cancel out.
  always_comb begin
    credits_d = credits_q;
    if (send && !credit_return) begin
      credits_d = credits_q - cred_w'(1);
    end else if (!send && credit_return && credits_q != cred_w'(credit_max)) begin
      credits_d = credits_q + cred_w'(1);
    end
  end

  // State, pointer, credits and the registered output flit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      ptr_q       <= idx_w'(num_req - 1);
      grant_q     <= '0;
      credits_q   <= cred_w'(credit_max);
      out_flit_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      credits_q   <= credits_d;
      out_valid_q <= send;
      if (send) out_flit_q <= sel_flit;
    end
  end

`ifdef SIM
  // Flag a credit return that arrives with the counter already full.
  always @(posedge clk) begin
    if (!rst && credit_return && !send && credits_q == cred_w'(credit_max)) begin
      $display("ERROR rr_port_scheduler: credit_return at full credit count ignored");
    end
  end
`endif

  assign out_flit  = out_flit_q;
  assign out_valid = out_valid_q;
  assign grant_id  = grant_q;
  assign locked    = (state_q == StLocked);
  assign credits   = credits_q;

endmodule

// File: tb/tb_rr_port_scheduler.sv
// Self-checking bench for rr_port_scheduler; watchdog scenario runs when LOCK_WATCHDOG_EN is set.
module tb_rr_port_scheduler;

  localparam int NR = 4;
  localparam int FW = 64;
  localparam int CM = 8;
  localparam int WD = 16;

  logic             clk, rst, credit_return;
  logic [NR-1:0]    req_empty, consume;
  logic [NR*FW-1:0] req_flit;
  logic [FW-1:0]    out_flit;
  logic             out_valid, locked, lock_err;
  logic [1:0]       grant_id;
  logic [3:0]       credits;

  rr_port_scheduler #(
    .num_req        (NR),
    .flit_width     (FW),
    .credit_max     (CM),
    .watchdog_cycles(WD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_empty    (req_empty),
    .req_flit     (req_flit),
    .consume      (consume),
    .credit_return(credit_return),
    .out_flit     (out_flit),
    .out_valid    (out_valid),
    .grant_id     (grant_id),
    .locked       (locked),
    .credits      (credits),
    .lock_err     (lock_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Input buffers modelled as ring FIFOs.
  logic [FW-1:0] fifo_mem[NR][256];
  int rd_p[NR];
  int cnt[NR];

  task automatic push_flit(input int i, input logic [FW-1:0] f);
    fifo_mem[i][(rd_p[i] + cnt[i]) % 256] = f;
    cnt[i]++;
  endtask

  task automatic push_packet(input int i, input int len);
    logic [FW-1:0] f;
    for (int k = 0; k < len; k++) begin
      f = {$urandom, $urandom};
      f[FW-1] = (k == len - 1);
      push_flit(i, f);
    end
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) begin
      rd_p[i] = 0;
      cnt[i]  = 0;
    end
  endtask

  function automatic int oh_idx(input logic [NR-1:0] v);
    for (int i = 0; i < NR; i++) if (v == (NR'(1) << i)) return i;
    return -1;
  endfunction

  // Behavioural model: owner of the current packet (-1 none), last winner, credits.
  int            m_owner, m_ptr, m_grant, m_credits, m_stall;
  bit            m_out_valid, m_lock_err, m_known;
  logic [FW-1:0] m_out_flit;

  initial begin
    m_known = 0;
    clear_queues();
    rst = 1'b1;
    credit_return = 1'b0;
    req_empty = '1;
    req_flit = '0;
  end

  // One clock cycle: check registered outputs, drive inputs, check consume, advance model.
  task automatic run_cycle(input bit rst_v, input bit cr_v);
    int win;
    logic [FW-1:0] f;
    @(negedge clk);
    if (m_known) begin
      chk("out_valid", out_valid, m_out_valid);
      if (m_out_valid) chk("out_flit", out_flit, m_out_flit);
      chk("grant_id", grant_id, m_grant);
      chk("locked", locked, m_owner >= 0);
      chk("credits", credits, m_credits);
      chk("lock_err", lock_err, m_lock_err);
    end
    rst = rst_v;
    credit_return = cr_v;
    for (int i = 0; i < NR; i++) begin
      req_empty[i] = (cnt[i] == 0);
      req_flit[i*FW +: FW] = (cnt[i] != 0) ? fifo_mem[i][rd_p[i]] : '0;
    end
    #1;
    win = -1;
    if (!rst_v && m_credits > 0) begin
      if (m_owner < 0) begin
        for (int k = 1; k <= NR; k++) begin
          if (win < 0 && cnt[(m_ptr + k) % NR] != 0) win = (m_ptr + k) % NR;
        end
      end else if (cnt[m_owner] != 0) begin
        win = m_owner;
      end
    end
    if (m_known || rst_v) chk("consume", consume, (win >= 0) ? (NR'(1) << win) : NR'(0));
    if (rst_v) begin
      m_known = 1; m_owner = -1; m_ptr = NR - 1; m_grant = 0; m_credits = CM;
      m_stall = 0; m_out_valid = 0; m_lock_err = 0;
    end else begin
      m_lock_err = 0;
      if (win >= 0) begin
        f = fifo_mem[win][rd_p[win]];
        rd_p[win] = (rd_p[win] + 1) % 256;
        cnt[win]--;
        m_out_valid = 1;
        m_out_flit = f;
        m_grant = win;
        m_ptr = win;
        m_owner = f[FW-1] ? -1 : win;
        m_stall = 0;
        if (!cr_v) m_credits--;
      end else begin
        m_out_valid = 0;
        if (cr_v && m_credits < CM) m_credits++;
`ifdef LOCK_WATCHDOG_EN
        if (m_owner >= 0 && cnt[m_owner] == 0) begin
          m_stall++;
          if (m_stall == WD) begin
            m_owner = -1;
            m_stall = 0;
            m_lock_err = 1;
          end
        end
`endif
      end
    end
  endtask

  task automatic do_reset();
    clear_queues();
    run_cycle(1, 0);
    run_cycle(1, 0);
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  int seq[5];
  int exp1[5] = '{0, 1, 2, 3, 0};
  int exp2[4] = '{1, 1, 1, 2};
  int n_sent, nerr, g3;

  initial begin
    // Reset values.
    do_reset();
    after_edge();
    chk("rst_locked", locked, 0);
    chk("rst_credits", credits, 8);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_grant_id", grant_id, 0);

    // Single-flit packets from every requester rotate 0,1,2,3,0.
    push_packet(0, 1); push_packet(1, 1); push_packet(2, 1); push_packet(3, 1);
    push_packet(0, 1);
    for (int c = 0; c < 5; c++) begin
      run_cycle(0, 0);
      seq[c] = oh_idx(consume);
    end
    for (int c = 0; c < 5; c++) chk($sformatf("rr_grant%0d", c), seq[c], exp1[c]);
    after_edge();
    chk("rr_out_valid", out_valid, 1);
    chk("rr_credits", credits, 3);

    // Three-flit packet from 1 holds the grant while 2 waits.
    do_reset();
    push_packet(1, 3); push_packet(2, 1);
    for (int c = 0; c < 4; c++) begin
      run_cycle(0, 0);
      seq[c] = oh_idx(consume);
      if (c == 0) begin
        after_edge();
        chk("pkt_locked", locked, 1);
      end
    end
    for (int c = 0; c < 4; c++) chk($sformatf("pkt_grant%0d", c), seq[c], exp2[c]);

    // Credit exhaustion, then a single returned credit buys exactly one send.
    do_reset();
    for (int k = 0; k < 10; k++) push_packet(0, 1);
    n_sent = 0;
    for (int c = 0; c < 9; c++) begin
      run_cycle(0, 0);
      if (consume != 0) n_sent++;
    end
    chk("cred_sent", n_sent, 8);
    chk("cred_stall_consume", consume, 0);
    after_edge();
    chk("cred_zero", credits, 0);
    run_cycle(0, 1);
    chk("cred_ret_cycle_consume", consume, 0);
    run_cycle(0, 0);
    chk("cred_one_send", consume, 4'b0001);
    run_cycle(0, 0);
    chk("cred_after_consume", consume, 0);
    after_edge();
    chk("cred_after", credits, 0);

    // Send plus return at 5 holds; return at full saturates.
    do_reset();
    for (int k = 0; k < 4; k++) push_packet(0, 1);
    for (int c = 0; c < 3; c++) run_cycle(0, 0);
    run_cycle(0, 1);
    after_edge();
    chk("cred_both", credits, 5);
    do_reset();
    run_cycle(0, 1);
    after_edge();
    chk("cred_sat", credits, 8);

    // Reset mid-packet.
    do_reset();
    push_packet(1, 4);
    run_cycle(0, 0);
    run_cycle(1, 0);
    after_edge();
    chk("midrst_locked", locked, 0);
    chk("midrst_credits", credits, 8);
    chk("midrst_out_valid", out_valid, 0);
    push_packet(0, 1);
    run_cycle(0, 0);
    chk("midrst_prio0", oh_idx(consume), 0);

`ifdef LOCK_WATCHDOG_EN
    // Owner 2 goes empty mid-packet; watchdog releases it and 3 is served.
    do_reset();
    push_flit(2, 64'h0000_0000_0000_0002);
    push_packet(3, 1);
    run_cycle(0, 0);
    chk("wd_first", oh_idx(consume), 2);
    nerr = 0;
    g3 = -1;
    for (int c = 0; c < 20; c++) begin
      run_cycle(0, 0);
      if (consume[3] && g3 < 0) g3 = c;
      after_edge();
      if (lock_err === 1'b1) nerr++;
    end
    chk("wd_pulses", nerr, 1);
    chk("wd_grant3_cycle", g3, 16);
`endif

    // Randomised traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NR; i++) begin
        if (cnt[i] < 6 && $urandom_range(5) == 0) push_packet(i, 1 + $urandom_range(3));
      end
      run_cycle($urandom_range(399) == 0, $urandom_range(1) == 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
